// File: rtl/camera_pkg.sv
// camera_pkg: shared defaults and pixel type for the camera line buffer
package camera_pkg;
  localparam int DW_DEF    = 36;
  localparam int XSIZE_DEF = 160;
  localparam int LINES_DEF = 4;
  typedef logic [DW_DEF-1:0] pixel_t;
endpackage

// File: rtl/camera_line_ram.sv
// camera_line_ram: simple dual-port RAM, one write port, registered read port (1-cycle latency)
// Ports: clk, rst_n (sync active-low, clears read register only), we/waddr/wdata write port,
//        re/raddr read request, rdata registered read data (holds when re=0)
module camera_line_ram
  import camera_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = LINES_DEF * XSIZE_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk)
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/camera_line_buffer.sv
// camera_line_buffer: ring of LINES complete camera lines; a line becomes readable only once fully written
// Ports: clk, rst_n (sync active-low), iFrameStart flush, iWrEn/iData write side,
//        iRdEn/oData/oValid read side (1-cycle latency), oLines/oFull/oEmpty occupancy,
//        oOverflow/oUnderflow sticky errors cleared by iClrErr.
// Build option: define CAMERA_LINE_BUFFER_ERR_EN to enable the sticky error flags (otherwise tied 0).
module camera_line_buffer
  import camera_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int XSIZE = XSIZE_DEF,
  parameter int LINES = LINES_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       iFrameStart,
  input  logic                       iWrEn,
  input  logic [DW-1:0]              iData,
  input  logic                       iRdEn,
  output logic [DW-1:0]              oData,
  output logic                       oValid,
  output logic [$clog2(LINES+1)-1:0] oLines,
  output logic                       oFull,
  output logic                       oEmpty,
  output logic                       oOverflow,
  output logic                       oUnderflow,
  input  logic                       iClrErr
);
  localparam int CW    = $clog2(XSIZE);
  localparam int LW    = $clog2(LINES);
  localparam int NW    = $clog2(LINES+1);
  localparam int DEPTH = LINES * XSIZE;
  localparam int AW    = $clog2(DEPTH);
  logic [CW-1:0] wcol, rcol;
  logic [LW-1:0] wline, rline;
  logic [AW-1:0] wbase, rbase;
  logic [NW-1:0] lines, lines_nxt;
  logic          wr_ok, rd_ok, commit, rel;
  // oFull/oEmpty mirror the registered line count, so they double as slot-free / line-ready gates
  assign wr_ok     = iWrEn && !iFrameStart && !oFull;
  assign rd_ok     = iRdEn && !iFrameStart && !oEmpty;
  assign commit    = wr_ok && wcol == CW'(XSIZE-1);
  assign rel       = rd_ok && rcol == CW'(XSIZE-1);
  assign lines_nxt = iFrameStart ? '0 : lines + NW'(commit) - NW'(rel);
  assign oLines    = lines;
  always_ff @(posedge clk)
    if (!rst_n) begin
      {wcol, rcol, wline, rline, wbase, rbase, lines} <= '0;
      oFull  <= 1'b0;
      oEmpty <= 1'b1;
      oValid <= 1'b0;
    end else begin
      lines  <= lines_nxt;
      oFull  <= lines_nxt == NW'(LINES);
      oEmpty <= lines_nxt == '0;
      oValid <= rd_ok;
      if (iFrameStart) begin
        {wcol, rcol, wline, rline, wbase, rbase} <= '0;
      end else begin
        // per-slot base addresses step by XSIZE so no multiplier is needed
        if (wr_ok) wcol <= commit ? '0 : wcol + 1'b1;
        if (commit) begin
          wline <= wline == LW'(LINES-1) ? '0 : wline + 1'b1;
          wbase <= wline == LW'(LINES-1) ? '0 : wbase + AW'(XSIZE);
        end
        if (rd_ok) rcol <= rel ? '0 : rcol + 1'b1;
        if (rel) begin
          rline <= rline == LW'(LINES-1) ? '0 : rline + 1'b1;
          rbase <= rline == LW'(LINES-1) ? '0 : rbase + AW'(XSIZE);
        end
      end
    end
  camera_line_ram #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_ok),
    .waddr (wbase + AW'(wcol)),
    .wdata (iData),
    .re    (rd_ok),
    .raddr (rbase + AW'(rcol)),
    .rdata (oData)
  );
`ifdef CAMERA_LINE_BUFFER_ERR_EN
  logic ovf, unf;
  always_ff @(posedge clk)
    if (!rst_n) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      ovf <= (iWrEn && !iFrameStart && oFull)  ? 1'b1 : iClrErr ? 1'b0 : ovf;
      unf <= (iRdEn && !iFrameStart && oEmpty) ? 1'b1 : iClrErr ? 1'b0 : unf;
    end
  assign oOverflow  = ovf;
  assign oUnderflow = unf;
`else
  logic unused_clr;
  assign unused_clr = iClrErr;
  assign oOverflow  = 1'b0;
  assign oUnderflow = 1'b0;
`endif
endmodule

// File: tb/tb_camera_line_buffer.sv
// tb_camera_line_buffer: directed self-checking bench for camera_line_buffer
module tb_camera_line_buffer;
`ifdef CAMERA_LINE_BUFFER_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst_n, iFrameStart, iWrEn, iRdEn, iClrErr;
  logic [35:0] iData, oData;
  logic        oValid, oFull, oEmpty, oOverflow, oUnderflow;
  logic [2:0]  oLines;
  int          errors = 0;
  int          checks = 0;

  camera_line_buffer dut (
    .clk(clk), .rst_n(rst_n), .iFrameStart(iFrameStart), .iWrEn(iWrEn), .iData(iData),
    .iRdEn(iRdEn), .oData(oData), .oValid(oValid), .oLines(oLines), .oFull(oFull),
    .oEmpty(oEmpty), .oOverflow(oOverflow), .oUnderflow(oUnderflow), .iClrErr(iClrErr)
  );

  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic wr_line(input int base);
    for (int c = 0; c < 160; c++) begin
      iWrEn = 1'b1; iData = 36'(base + c); cyc;
    end
    iWrEn = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; iFrameStart = 1'b0; iWrEn = 1'b0; iRdEn = 1'b0; iClrErr = 1'b0; iData = '0;
    cyc; cyc;
    checks++; if (oLines !== 3'd0) begin errors++; $display("FAIL reset_lines got=%0d exp=0", oLines); end
    checks++; if (oEmpty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", oEmpty); end
    checks++; if (oFull !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", oFull); end
    checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", oValid); end
    checks++; if (oData !== 36'd0) begin errors++; $display("FAIL reset_data got=%0d exp=0", oData); end
    checks++; if (oOverflow !== 1'b0 || oUnderflow !== 1'b0) begin errors++; $display("FAIL reset_err got=%b%b exp=00", oOverflow, oUnderflow); end
    rst_n = 1'b1;
    cyc;
  endtask

  task automatic test_one_line;
    for (int c = 0; c < 160; c++) begin
      iWrEn = 1'b1; iData = 36'(c); cyc;
      if (c == 158) begin
        checks++; if (oLines !== 3'd0 || oEmpty !== 1'b1) begin errors++; $display("FAIL partial_line lines=%0d empty=%b exp=0/1", oLines, oEmpty); end
      end
      if (c == 159) begin
        checks++; if (oLines !== 3'd1 || oEmpty !== 1'b0) begin errors++; $display("FAIL line_commit lines=%0d empty=%b exp=1/0", oLines, oEmpty); end
      end
    end
    iWrEn = 1'b0;
  endtask

  task automatic test_full_overflow;
    wr_line(1000); wr_line(2000); wr_line(3000);
    checks++; if (oLines !== 3'd4 || oFull !== 1'b1) begin errors++; $display("FAIL full lines=%0d full=%b exp=4/1", oLines, oFull); end
    iWrEn = 1'b1; iData = 36'd9999; cyc; iWrEn = 1'b0;
    checks++; if (oLines !== 3'd4) begin errors++; $display("FAIL drop_lines got=%0d exp=4", oLines); end
    checks++; if (oOverflow !== ERR) begin errors++; $display("FAIL overflow got=%b exp=%b", oOverflow, ERR); end
    iClrErr = 1'b1; cyc; iClrErr = 1'b0;
    checks++; if (oOverflow !== 1'b0) begin errors++; $display("FAIL overflow_clr got=%b exp=0", oOverflow); end
    for (int c = 0; c < 160; c++) begin
      iRdEn = 1'b1; cyc;
      checks++; if (oValid !== 1'b1 || oData !== 36'(c)) begin errors++; $display("FAIL rd_line0[%0d] valid=%b data=%0d exp=1/%0d", c, oValid, oData, c); end
      if (c == 158) begin
        checks++; if (oLines !== 3'd4) begin errors++; $display("FAIL release_early got=%0d exp=4", oLines); end
      end
    end
    iRdEn = 1'b0;
    checks++; if (oLines !== 3'd3 || oFull !== 1'b0) begin errors++; $display("FAIL release lines=%0d full=%b exp=3/0", oLines, oFull); end
    cyc;
    checks++; if (oValid !== 1'b0 || oData !== 36'd159) begin errors++; $display("FAIL hold valid=%b data=%0d exp=0/159", oValid, oData); end
  endtask

  task automatic test_back_to_back;
    for (int c = 0; c < 160; c++) begin
      iRdEn = 1'b1; cyc;
      checks++; if (oData !== 36'(1000 + c)) begin errors++; $display("FAIL rd_line1[%0d] got=%0d exp=%0d", c, oData, 1000 + c); end
    end
    iRdEn = 1'b0;
    checks++; if (oLines !== 3'd2) begin errors++; $display("FAIL pre_simul got=%0d exp=2", oLines); end
    for (int c = 0; c < 160; c++) begin
      iWrEn = 1'b1; iData = 36'(4000 + c); iRdEn = 1'b1; cyc;
      checks++; if (oValid !== 1'b1 || oData !== 36'(2000 + c)) begin errors++; $display("FAIL simul[%0d] valid=%b data=%0d exp=1/%0d", c, oValid, oData, 2000 + c); end
    end
    iWrEn = 1'b0; iRdEn = 1'b0;
    checks++; if (oLines !== 3'd2) begin errors++; $display("FAIL simul_lines got=%0d exp=2", oLines); end
    for (int l = 3; l <= 4; l++)
      for (int c = 0; c < 160; c++) begin
        iRdEn = 1'b1; cyc;
        checks++; if (oData !== 36'(l * 1000 + c)) begin errors++; $display("FAIL wrap_rd[%0d][%0d] got=%0d exp=%0d", l, c, oData, l * 1000 + c); end
      end
    iRdEn = 1'b0;
    checks++; if (oLines !== 3'd0 || oEmpty !== 1'b1) begin errors++; $display("FAIL drained lines=%0d empty=%b exp=0/1", oLines, oEmpty); end
  endtask

  task automatic test_underflow;
    iRdEn = 1'b1; cyc; iRdEn = 1'b0;
    checks++; if (oValid !== 1'b0 || oData !== 36'd4159) begin errors++; $display("FAIL underflow_rd valid=%b data=%0d exp=0/4159", oValid, oData); end
    checks++; if (oUnderflow !== ERR) begin errors++; $display("FAIL underflow got=%b exp=%b", oUnderflow, ERR); end
    checks++; if (oLines !== 3'd0) begin errors++; $display("FAIL underflow_lines got=%0d exp=0", oLines); end
    iClrErr = 1'b1; cyc; iClrErr = 1'b0;
    checks++; if (oUnderflow !== 1'b0) begin errors++; $display("FAIL underflow_clr got=%b exp=0", oUnderflow); end
  endtask

  task automatic test_frame_start;
    for (int c = 0; c < 80; c++) begin
      iWrEn = 1'b1; iData = 36'(5000 + c); cyc;
    end
    iWrEn = 1'b0; iFrameStart = 1'b1; cyc; iFrameStart = 1'b0;
    checks++; if (oLines !== 3'd0) begin errors++; $display("FAIL flush_lines got=%0d exp=0", oLines); end
    wr_line(6000);
    checks++; if (oLines !== 3'd1) begin errors++; $display("FAIL flush_commit got=%0d exp=1", oLines); end
    for (int c = 0; c < 160; c++) begin
      iRdEn = 1'b1; cyc;
      checks++; if (oData !== 36'(6000 + c)) begin errors++; $display("FAIL flush_rd[%0d] got=%0d exp=%0d", c, oData, 6000 + c); end
    end
    iRdEn = 1'b0;
    checks++; if (oEmpty !== 1'b1) begin errors++; $display("FAIL flush_empty got=%b exp=1", oEmpty); end
  endtask

  task automatic test_reset_mid;
    wr_line(7000); wr_line(8000); wr_line(9000);
    for (int c = 0; c < 370; c++) begin
      iRdEn = 1'b1; cyc;
    end
    checks++; if (oData !== 36'd9049 || oLines !== 3'd1) begin errors++; $display("FAIL mid_read data=%0d lines=%0d exp=9049/1", oData, oLines); end
    rst_n = 1'b0; cyc; rst_n = 1'b1; iRdEn = 1'b0;
    checks++; if (oLines !== 3'd0 || oEmpty !== 1'b1 || oFull !== 1'b0) begin errors++; $display("FAIL mid_rst_occ lines=%0d empty=%b full=%b exp=0/1/0", oLines, oEmpty, oFull); end
    checks++; if (oValid !== 1'b0 || oData !== 36'd0) begin errors++; $display("FAIL mid_rst_data valid=%b data=%0d exp=0/0", oValid, oData); end
    checks++; if (oOverflow !== 1'b0 || oUnderflow !== 1'b0) begin errors++; $display("FAIL mid_rst_err got=%b%b exp=00", oOverflow, oUnderflow); end
    iRdEn = 1'b1; cyc; iRdEn = 1'b0;
    checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL post_rst_rd got=%b exp=0", oValid); end
    wr_line(100);
    iRdEn = 1'b1; cyc; iRdEn = 1'b0;
    checks++; if (oValid !== 1'b1 || oData !== 36'd100) begin errors++; $display("FAIL post_rst_data valid=%b data=%0d exp=1/100", oValid, oData); end
  endtask

  initial begin
    test_reset;
    test_one_line;
    test_full_overflow;
    test_back_to_back;
    test_underflow;
    test_frame_start;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
